// File: rtl/dcacheread_bus_port.sv
// Uncached/miss read path behind the dcache read link: issues one burst of 32-bit
// bus reads per request and returns byte-aligned 64-bit data with a done pulse.
module dcacheread_bus_port (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_dcacheread_do,
    output logic        req_dcacheread_done,
    input  logic [3:0]  req_dcacheread_length,
    input  logic        req_dcacheread_cache_disable,
    input  logic [31:0] req_dcacheread_address,
    output logic [63:0] req_dcacheread_data,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [1:0]  avm_burstcount,
    output logic        avm_cache_disable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    typedef enum logic [1:0] {StIdle, StIssue, StCollect, StDone} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_addr;
    logic [3:0]  r_len;
    logic        r_cd;
    logic [1:0]  r_burst;
    logic [1:0]  r_beat;
    logic [95:0] r_buf;
    logic [63:0] r_data;

    logic [3:0]  w_len_clamp;
    logic [3:0]  w_sum;
    logic [1:0]  w_burst;
    logic        w_load;
    logic        w_beat_we;
    logic [95:0] w_buf_next;
    logic [95:0] w_shifted;
    logic [63:0] w_asm;
    logic        w_enter_done;

    assign w_len_clamp = (req_dcacheread_length > 4'd8) ? 4'd8 : req_dcacheread_length;
    assign w_sum       = {2'b00, req_dcacheread_address[1:0]} + w_len_clamp + 4'd3;
    assign w_burst     = 2'(w_sum >> 2);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_beat_we    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (req_dcacheread_do) begin
                    w_load       = 1'b1;
                    w_state_next = (w_len_clamp == 4'd0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (!avm_waitrequest) begin
                    w_state_next = StCollect;
                end
            end
            StCollect: begin
                if (avm_readdatavalid) begin
                    w_beat_we = 1'b1;
                    if (r_beat == r_burst - 2'd1) begin
                        w_state_next = StDone;
                    end
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Next buffer includes the beat arriving this cycle so the last beat feeds assembly.
    always_comb begin
        w_buf_next = r_buf;
        if (w_beat_we) begin
            case (r_beat)
                2'd0:    w_buf_next[31:0]  = avm_readdata;
                2'd1:    w_buf_next[63:32] = avm_readdata;
                2'd2:    w_buf_next[95:64] = avm_readdata;
                default: w_buf_next = r_buf;
            endcase
        end
    end

    always_comb begin
        w_shifted = w_buf_next >> {r_addr[1:0], 3'b000};
        w_asm     = w_shifted[63:0];
        for (int i = 0; i < 8; i++) begin
            if (4'(i) >= r_len) begin
                w_asm[8*i +: 8] = 8'h00;
            end
        end
    end

    assign w_enter_done = (w_state_next == StDone) && (r_state != StDone);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_addr  <= '0;
            r_len   <= '0;
            r_cd    <= 1'b0;
            r_burst <= '0;
            r_beat  <= '0;
            r_buf   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_addr  <= req_dcacheread_address;
                r_len   <= w_len_clamp;
                r_cd    <= req_dcacheread_cache_disable;
                r_burst <= w_burst;
                r_beat  <= '0;
            end else if (w_beat_we) begin
                r_beat <= r_beat + 2'd1;
            end
            r_buf <= w_buf_next;
            // Zero-length requests complete straight from idle with zero data.
            if (w_enter_done) begin
                r_data <= (r_state == StIdle) ? 64'd0 : w_asm;
            end
        end
    end

    assign avm_read            = (r_state == StIssue);
    assign avm_address         = {r_addr[31:2], 2'b00};
    assign avm_burstcount      = r_burst;
    assign avm_cache_disable   = r_cd;
    assign req_dcacheread_done = (r_state == StDone);
    assign req_dcacheread_data = r_data;

endmodule

// File: tb/tb_dcacheread_bus_port.sv
// Bench for dcacheread_bus_port: directed vector table, hand sequences for stalls and
// reset, and randomized requests checked against a byte-level reference model.
module tb_dcacheread_bus_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_dcacheread_do;
    logic        req_dcacheread_done;
    logic [3:0]  req_dcacheread_length;
    logic        req_dcacheread_cache_disable;
    logic [31:0] req_dcacheread_address;
    logic [63:0] req_dcacheread_data;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [1:0]  avm_burstcount;
    logic        avm_cache_disable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    int errors = 0;
    int checks = 0;

    dcacheread_bus_port dut (
        .clk                          (clk),
        .rst                          (rst),
        .req_dcacheread_do            (req_dcacheread_do),
        .req_dcacheread_done          (req_dcacheread_done),
        .req_dcacheread_length        (req_dcacheread_length),
        .req_dcacheread_cache_disable (req_dcacheread_cache_disable),
        .req_dcacheread_address       (req_dcacheread_address),
        .req_dcacheread_data          (req_dcacheread_data),
        .avm_address                  (avm_address),
        .avm_read                     (avm_read),
        .avm_burstcount               (avm_burstcount),
        .avm_cache_disable            (avm_cache_disable),
        .avm_waitrequest              (avm_waitrequest),
        .avm_readdata                 (avm_readdata),
        .avm_readdatavalid            (avm_readdatavalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        logic        cd;
        int          wt;
        int          gap;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [31:0] b2;
        logic [1:0]  exp_burst;
        logic [63:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: lay the beats out as a little-endian byte stream, pick len bytes.
    function automatic logic [63:0] ref_data(input logic [31:0] addr, input logic [3:0] len,
                                             input logic [31:0] b0, input logic [31:0] b1,
                                             input logic [31:0] b2);
        logic [31:0] bt[3];
        logic [7:0]  bytes[12];
        logic [63:0] res;
        int          l;
        bt[0] = b0;
        bt[1] = b1;
        bt[2] = b2;
        l = (len > 8) ? 8 : int'(len);
        for (int i = 0; i < 12; i++) bytes[i] = bt[i / 4][8 * (i % 4) +: 8];
        res = '0;
        for (int j = 0; j < l; j++) res[8 * j +: 8] = bytes[int'(addr[1:0]) + j];
        return res;
    endfunction

    function automatic logic [1:0] ref_burst(input logic [31:0] addr, input logic [3:0] len);
        int l;
        l = (len > 8) ? 8 : int'(len);
        return 2'((int'(addr[1:0]) + l + 3) / 4);
    endfunction

    // Called at a negedge while the DUT is idle; returns at the negedge after done.
    task automatic run_req(input logic [31:0] addr, input logic [3:0] len, input logic cd,
                           input int wt, input int gap, input logic [31:0] b0,
                           input logic [31:0] b1, input logic [31:0] b2,
                           input logic [1:0] exp_burst, input logic [63:0] exp_data);
        logic [31:0] bt[3];
        int          cyc;
        int          exp_cyc;
        bt[0] = b0;
        bt[1] = b1;
        bt[2] = b2;
        cyc = 0;
        req_dcacheread_do            = 1'b1;
        req_dcacheread_address       = addr;
        req_dcacheread_length        = len;
        req_dcacheread_cache_disable = cd;
        avm_waitrequest              = (wt > 0);
        avm_readdatavalid            = 1'b0;
        if (len == 4'd0) begin
            @(negedge clk);
            cyc++;
            chk("len0_done", 64'(req_dcacheread_done), 64'd1);
            chk("len0_noread", 64'(avm_read), 64'd0);
            chk("len0_data", req_dcacheread_data, 64'd0);
        end else begin
            do begin
                @(negedge clk);
                cyc++;
            end while (!avm_read && cyc < 8);
            if (!avm_read) begin
                chk("read_timeout", 64'(avm_read), 64'd1);
                req_dcacheread_do = 1'b0;
                return;
            end
            chk("issue_cycle", 64'(cyc), 64'd1);
            chk("avm_address", 64'(avm_address), 64'({addr[31:2], 2'b00}));
            chk("burstcount", 64'(avm_burstcount), 64'(exp_burst));
            chk("cache_disable", 64'(avm_cache_disable), 64'(cd));
            for (int s = 0; s < wt; s++) begin
                @(negedge clk);
                cyc++;
                chk("stall_read", 64'(avm_read), 64'd1);
                chk("stall_addr", 64'(avm_address), 64'({addr[31:2], 2'b00}));
                chk("stall_burst", 64'(avm_burstcount), 64'(exp_burst));
            end
            avm_waitrequest = 1'b0;
            @(negedge clk);
            cyc++;
            for (int k = 0; k < int'(exp_burst); k++) begin
                if (k > 0) begin
                    for (int g = 0; g < gap; g++) begin
                        avm_readdatavalid = 1'b0;
                        @(negedge clk);
                        cyc++;
                    end
                end
                avm_readdatavalid = 1'b1;
                avm_readdata      = bt[k];
                @(negedge clk);
                cyc++;
            end
            avm_readdatavalid = 1'b0;
            exp_cyc = 2 + wt + int'(exp_burst) + gap * (int'(exp_burst) - 1);
            chk("done_cycle", 64'(cyc), 64'(exp_cyc));
            chk("done", 64'(req_dcacheread_done), 64'd1);
            chk("done_noread", 64'(avm_read), 64'd0);
            chk("data", req_dcacheread_data, exp_data);
        end
        // Upstream keeps do high through the done cycle; the DUT must not re-accept.
        @(negedge clk);
        req_dcacheread_do = 1'b0;
        chk("done_pulse_single", 64'(req_dcacheread_done), 64'd0);
        chk("no_reaccept", 64'(avm_read), 64'd0);
        chk("data_hold", req_dcacheread_data, exp_data);
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  rl;
        logic [31:0] rb0, rb1, rb2;

        vecs[0] = '{32'h0000_1000, 4'd4, 1'b0, 0, 0, 32'hDEADBEEF, 32'h0, 32'h0,
                    2'd1, 64'h0000_0000_DEAD_BEEF};
        vecs[1] = '{32'h0000_1003, 4'd8, 1'b1, 0, 0, 32'h44332211, 32'h88776655,
                    32'hCCBBAA99, 2'd3, 64'hBBAA_9988_7766_5544};
        vecs[2] = '{32'h0000_2003, 4'd2, 1'b0, 0, 0, 32'h44332211, 32'h88776655, 32'h0,
                    2'd2, 64'h0000_0000_0000_5544};
        vecs[3] = '{32'h0000_2002, 4'd4, 1'b1, 3, 2, 32'h44332211, 32'h88776655, 32'h0,
                    2'd2, 64'h0000_0000_6655_4433};
        vecs[4] = '{32'h0000_3000, 4'd0, 1'b0, 0, 0, 32'h0, 32'h0, 32'h0,
                    2'd0, 64'h0};
        vecs[5] = '{32'h0000_3000, 4'd12, 1'b0, 0, 0, 32'h03020100, 32'h07060504, 32'h0,
                    2'd2, 64'h0706_0504_0302_0100};

        rst                          = 1'b1;
        req_dcacheread_do            = 1'b0;
        req_dcacheread_length        = '0;
        req_dcacheread_cache_disable = 1'b0;
        req_dcacheread_address       = '0;
        avm_waitrequest              = 1'b0;
        avm_readdata                 = '0;
        avm_readdatavalid            = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_done", 64'(req_dcacheread_done), 64'd0);
        chk("rst_data", req_dcacheread_data, 64'd0);
        chk("rst_read", 64'(avm_read), 64'd0);
        chk("rst_addr", 64'(avm_address), 64'd0);
        chk("rst_burst", 64'(avm_burstcount), 64'd0);
        chk("rst_cd", 64'(avm_cache_disable), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i].addr, vecs[i].len, vecs[i].cd, vecs[i].wt, vecs[i].gap,
                    vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].exp_burst, vecs[i].exp_data);
        end

        // Stray beats while idle must not advance the beat counter.
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("stray_no_done", 64'(req_dcacheread_done), 64'd0);
        avm_readdatavalid = 1'b0;
        run_req(32'h0000_4002, 4'd2, 1'b0, 0, 0, 32'h12345678, 32'h0, 32'h0,
                2'd1, 64'h0000_0000_0000_1234);

        // Reset after the first of three beats.
        req_dcacheread_do            = 1'b1;
        req_dcacheread_address       = 32'h0000_1003;
        req_dcacheread_length        = 4'd8;
        req_dcacheread_cache_disable = 1'b1;
        avm_waitrequest              = 1'b0;
        @(negedge clk);
        @(negedge clk);
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hA5A5_A5A5;
        @(negedge clk);
        avm_readdatavalid = 1'b0;
        req_dcacheread_do = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_done", 64'(req_dcacheread_done), 64'd0);
        chk("mid_rst_data", req_dcacheread_data, 64'd0);
        chk("mid_rst_read", 64'(avm_read), 64'd0);
        chk("mid_rst_addr", 64'(avm_address), 64'd0);
        chk("mid_rst_burst", 64'(avm_burstcount), 64'd0);
        chk("mid_rst_cd", 64'(avm_cache_disable), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_req(32'h0000_1003, 4'd8, 1'b0, 0, 0, 32'h44332211, 32'h88776655, 32'hCCBBAA99,
                2'd3, 64'hBBAA_9988_7766_5544);

        for (int n = 0; n < 40; n++) begin
            ra  = $urandom;
            rl  = 4'($urandom_range(0, 15));
            rb0 = $urandom;
            rb1 = $urandom;
            rb2 = $urandom;
            run_req(ra, rl, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), rb0, rb1, rb2, ref_burst(ra, rl),
                    ref_data(ra, rl, rb0, rb1, rb2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcacheread_bus_port.md
# dcacheread_bus_port

Downstream consumer of the data-cache read link stage: it accepts the held read request (length, address, cache-disable) and performs it as a single pipelined burst of 32-bit bus reads. It assembles the returned beats into a byte-aligned 64-bit result and returns it with a one-cycle done pulse. It serves as the uncached / miss read path behind the dcache read link, with one outstanding request at a time.

## Interface
- No parameters.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_dcacheread_do  in  1  request valid; held high by upstream until done.
- req_dcacheread_done  out  1  one-cycle completion pulse.
- req_dcacheread_length  in  4  byte count, 1..8 legal.
- req_dcacheread_cache_disable  in  1  forwarded as bus attribute.
- req_dcacheread_address  in  32  byte address.
- req_dcacheread_data  out  64  result, byte 0 of request in bits [7:0].
- avm_address  out  32  dword-aligned burst start address.
- avm_read  out  1  read command.
- avm_burstcount  out  2  beats in burst, 1..3.
- avm_cache_disable  out  1  latched cache_disable.
- avm_waitrequest  in  1  command stall.
- avm_readdata  in  32  beat data, little-endian.
- avm_readdatavalid  in  1  beat valid.

## Operation
- States: IDLE, ISSUE, COLLECT, DONE.
- IDLE: on req_dcacheread_do=1, latch address, length, cache_disable.
  - Length 9..15 is clamped to 8.
  - Length 0 goes directly to DONE with data 0 and no bus command.
  - Otherwise go to ISSUE.
- Beat count N = (address[1:0] + length + 3) >> 2, range 1..3, 2-bit result.
- ISSUE: avm_read=1, avm_address={addr[31:2],2'b00}, avm_burstcount=N, avm_cache_disable=latched value.
  - All command outputs stay stable while avm_waitrequest=1.
  - Go to COLLECT on the first cycle with avm_waitrequest=0.
- COLLECT: avm_read=0. Each avm_readdatavalid beat k (0..N-1) is written into bits [32k+31:32k] of a 96-bit buffer via a 2-bit beat counter.
  - The last beat (k=N-1) moves the FSM to DONE.
- DONE: req_dcacheread_done=1 for exactly one cycle, then IDLE.
- Data assembly, registered on entry to DONE:
  - Shift the buffer right by 8*address[1:0].
  - Take the low 64 bits.
  - Zero bytes at index >= length.
- req_dcacheread_data holds its value until the next DONE; it is valid at least while done=1.
- avm_readdatavalid is ignored in IDLE, ISSUE and DONE.
- Reset is asynchronous: state→IDLE, buffer cleared, counters cleared. The bus is reset together with this block, so no stale beats are tracked.

## Timing
- Reset values: req_dcacheread_done=0, req_dcacheread_data=0, avm_read=0, avm_address=0, avm_burstcount=0, avm_cache_disable=0.
- Cycle 0: IDLE samples req_dcacheread_do=1.
- Cycle 1: avm_read=1, the earliest command issue.
- With waitrequest=0 at cycle 1 and N beats on consecutive cycles from cycle 2, done=1 at cycle N+2.
  - Minimum latency for N=1: done at cycle 3.
- Each waitrequest cycle adds one cycle; each gap between beats adds one cycle.
- Length 0: done=1 at cycle 1.
- Upstream still shows req_dcacheread_do=1 during the done cycle. The block is in DONE then and must not re-accept. A new request is first sampled the cycle after done.
- Back-to-back requests: the minimum gap from one done pulse to the next avm_read is 2 cycles.
- A readdatavalid beat in the same cycle the command is accepted is not possible on this bus and needs no handling.

## Test plan
- Aligned read:
  - Stimulus: length=4 at 0x0000_1000, waitrequest=0, beat 0xDEADBEEF at cycle 2.
  - Response: avm_address=0x1000, burstcount=1, done at cycle 3, data=0x0000_0000_DEAD_BEEF.
- Unaligned 8-byte read:
  - Stimulus: length=8 at 0x0000_1003, beats 0x44332211, 0x88776655, 0xCCBBAA99.
  - Response: avm_address=0x1000, burstcount=3, data=0xBBAA_9988_7766_5544.
- Short read crossing a dword:
  - Stimulus: length=2 at 0x0000_2003, beats 0x44332211, 0x88776655.
  - Response: burstcount=2, data=0x0000_0000_0000_5544.
- Stall and gaps:
  - Stimulus: waitrequest high for 3 cycles, 2-cycle gap between beats of a 2-beat burst.
  - Response: avm_read/address/burstcount stable through the stall; single done pulse; correct data; stray readdatavalid in IDLE ignored.
- Length 0 and clamp:
  - Stimulus: length=0, then length=12 at 0x3000.
  - Response: first gives no avm_read, done at cycle 1, data=0; second behaves as length 8 with burstcount=2.
- Reset mid-COLLECT:
  - Stimulus: assert rst after the first of 3 beats.
  - Response: outputs immediately return to reset values. The next request completes with correct data, with no contamination from the earlier beat.
